box_scan: RTL and testbench

- Region reader for the video framebuffer; the read-side counterpart of the square pixel drawer.
- On start, scans a size×size square at (x_in, y_in) through a 1-cycle-latency framebuffer read port.
- Stops at the first pixel whose colour differs from the background and reports it.
- Used by the ball/brick collision logic to probe the cells ahead of the ball before it is redrawn.

---
 rtl/box_scan_pkg.sv | 21 ++
 rtl/box_scan_if.sv | 19 +
 rtl/scan_counter.sv | 46 ++++
 rtl/box_scan.sv | 136 +++++++++++++
 tb/tb_box_scan.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/box_scan_pkg.sv
// Shared definitions for the framebuffer region reader, the square pixel
// drawer and the VGA adapter: coordinate width, screen geometry defaults
// and the scan FSM state encoding.
package box_scan_pkg;

   localparam int unsigned COORD_W      = 10;
   localparam int unsigned COLOR_W_DEF  = 3;
   localparam int unsigned SCREEN_W_DEF = 160;
   localparam int unsigned SCREEN_H_DEF = 120;

   typedef logic [COORD_W-1:0] coord_t;

   // Scan FSM encoding.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/box_scan_if.sv
// Framebuffer read port: the reader drives a strobe plus coordinates and
// the framebuffer returns the pixel colour one cycle later.
interface box_scan_if
   import box_scan_pkg::*;
#(
   parameter int unsigned COLOR_W = COLOR_W_DEF
) ();

   logic               rd_en;
   coord_t             x_rd;
   coord_t             y_rd;
   logic [COLOR_W-1:0] rd_data;

   // Reader side.
   modport master (output rd_en, x_rd, y_rd, input rd_data);
   // Framebuffer side.
   modport slave  (input rd_en, x_rd, y_rd, output rd_data);

endinterface

// File: rtl/scan_counter.sv
// 10-bit column-major x/y offset counter pair. load clears both offsets
// and latches the last offset value (side length minus one); each step
// advances y, and wraps y to 0 while advancing x at the end of a column.
module scan_counter
   import box_scan_pkg::*;
(
   input  logic   clk,
   input  logic   resetn,
   input  logic   load,
   input  coord_t last_in,
   input  logic   step,
   output coord_t x_off,
   output coord_t y_off,
   output logic   finished_col,
   output logic   finished_all
);

   coord_t last_q;

   // End detection is by equality, so a side of up to 1023 never overflows.
   assign finished_col = (y_off == last_q);
   assign finished_all = finished_col && (x_off == last_q);

   // Offset registers: cleared on load, advanced column-major on step.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         x_off  <= '0;
         y_off  <= '0;
         last_q <= '0;
      end else if (load) begin
         x_off  <= '0;
         y_off  <= '0;
         last_q <= last_in;
      end else if (step) begin
         if (finished_col) begin
            y_off <= '0;
            x_off <= x_off + COORD_W'(1);
         end else begin
            y_off <= y_off + COORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/box_scan.sv
// Region reader: scans a size x size square through a 1-cycle-latency
// framebuffer read port and stops at the first non-background pixel.
// Off-screen pixels are stepped over without a read and count as background.
module box_scan
   import box_scan_pkg::*;
#(
   parameter int unsigned COLOR_W  = COLOR_W_DEF,
   parameter int unsigned BG_COLOR = 0,
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  coord_t             x_in,
   input  coord_t             y_in,
   input  coord_t             size,
   box_scan_if.master         fb,
   output logic               busy,
   output logic               done,
   output logic               hit,
   output coord_t             hit_x,
   output coord_t             hit_y,
   output logic [COLOR_W-1:0] hit_color
);

   state_t state;
   coord_t x0, y0;
   coord_t x_off, y_off;
   coord_t x_cur, y_cur;
   logic   fin_col, fin_all;
   logic   cnt_load, cnt_step;
   logic   on_screen;
   logic   got_hit;

   // Read-valid bit and its coordinates, delayed to line up with rd_data.
   logic   vld_q;
   coord_t px_q, py_q;

   // Current pixel; the 10-bit adds wrap mod 1024 by construction.
   assign x_cur     = x0 + x_off;
   assign y_cur     = y0 + y_off;
   assign on_screen = (x_cur < COORD_W'(SCREEN_W)) && (y_cur < COORD_W'(SCREEN_H));

   assign fb.rd_en  = (state == S_SCAN) && on_screen;
   assign fb.x_rd   = x_cur;
   assign fb.y_rd   = y_cur;

   // Only reads returning while the scan is live count; the read issued in
   // the hit cycle returns in DONE and is ignored.
   assign got_hit  = vld_q && (fb.rd_data != COLOR_W'(BG_COLOR)) &&
                     ((state == S_SCAN) || (state == S_DRAIN));

   assign cnt_load = (state == S_IDLE) && start;
   assign cnt_step = (state == S_SCAN) && !got_hit && !fin_all;

   scan_counter u_cnt (
      .clk          (clk),
      .resetn       (resetn),
      .load         (cnt_load),
      .last_in      (size - COORD_W'(1)),
      .step         (cnt_step),
      .x_off        (x_off),
      .y_off        (y_off),
      .finished_col (fin_col),
      .finished_all (fin_all)
   );

   // Scan FSM with registered status outputs and first-hit capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         x0        <= '0;
         y0        <= '0;
         vld_q     <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit       <= 1'b0;
         hit_x     <= '0;
         hit_y     <= '0;
         hit_color <= '0;
      end else begin
         vld_q <= fb.rd_en;
         px_q  <= x_cur;
         py_q  <= y_cur;

         if (got_hit) begin
            hit       <= 1'b1;
            hit_x     <= px_q;
            hit_y     <= py_q;
            hit_color <= fb.rd_data;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  x0        <= x_in;
                  y0        <= y_in;
                  hit       <= 1'b0;
                  hit_x     <= '0;
                  hit_y     <= '0;
                  hit_color <= '0;
                  busy      <= 1'b1;
                  if (size == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_SCAN;
                  end
               end
            end
            S_SCAN: begin
               if (got_hit) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (fin_all) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_box_scan.sv
// Testbench for box_scan: framebuffer model, directed scenarios and
// randomized squares checked against a scan-order reference model.
module tb_box_scan;
   import box_scan_pkg::*;

   localparam int W = 160;
   localparam int H = 120;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   coord_t     x_in = '0, y_in = '0, size = '0;
   logic       busy, done, hit;
   coord_t     hit_x, hit_y;
   logic [2:0] hit_color;

   box_scan_if #(.COLOR_W(3)) fb_if ();

   box_scan #(.COLOR_W(3), .BG_COLOR(0), .SCREEN_W(W), .SCREEN_H(H)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .size      (size),
      .fb        (fb_if.master),
      .busy      (busy),
      .done      (done),
      .hit       (hit),
      .hit_x     (hit_x),
      .hit_y     (hit_y),
      .hit_color (hit_color)
   );

   always #5 clk = ~clk;

   logic [2:0] fb_mem [W*H];
   int n_cmp = 0, n_err = 0;
   int n_off_reads = 0;

   // Framebuffer model: 1-cycle read latency; garbage (never background)
   // on the data lines whenever no read was issued.
   always @(posedge clk) begin
      if (fb_if.rd_en) begin
         if (fb_if.x_rd < coord_t'(W) && fb_if.y_rd < coord_t'(H))
            fb_if.rd_data <= fb_mem[int'(fb_if.y_rd) * W + int'(fb_if.x_rd)];
         else begin
            n_off_reads++;
            fb_if.rd_data <= 3'($urandom_range(1, 7));
         end
      end else begin
         fb_if.rd_data <= 3'($urandom_range(1, 7));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_fb();
      for (int i = 0; i < W*H; i++) fb_mem[i] = 3'd0;
   endtask

   // Reference model: walk the square in column-major order with plain
   // arithmetic; list the reads that must appear and locate the first hit.
   int exp_rd[$], act_rd[$];
   int exp_hit, exp_hx, exp_hy, exp_hc, exp_lat;

   task automatic model(input int x0, input int y0, input int n);
      int hk, x, y;
      exp_rd.delete();
      exp_hit = 0; exp_hx = 0; exp_hy = 0; exp_hc = 0;
      hk = -1;
      for (int k = 0; k < n*n; k++) begin
         x = (x0 + k / n) % 1024;
         y = (y0 + k % n) % 1024;
         if (x < W && y < H) begin
            exp_rd.push_back(x * 1024 + y);
            if (hk < 0 && fb_mem[y*W + x] != 3'd0) begin
               hk = k; exp_hit = 1; exp_hx = x; exp_hy = y;
               exp_hc = int'(fb_mem[y*W + x]);
            end
         end
         if (hk >= 0 && k > hk) break;
      end
      exp_lat = (n == 0) ? 1 : (hk >= 0) ? hk + 3 : n*n + 2;
   endtask

   task automatic run_scan(input string name, input int x0, input int y0, input int n, input bit poke);
      int lat;
      model(x0, y0, n);
      act_rd.delete();
      n_off_reads = 0;
      lat = 0;
      @(negedge clk);
      x_in = coord_t'(x0); y_in = coord_t'(y0); size = coord_t'(n); start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 5000; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            check({name, " busy"}, busy, 1);
         end
         if (poke && i == 3) begin
            start = 1'b1; x_in = coord_t'(x0 + 40); size = coord_t'(n + 2);
         end
         if (poke && i == 4) begin
            start = 1'b0; x_in = coord_t'(x0); size = coord_t'(n);
         end
         if (fb_if.rd_en) act_rd.push_back(int'(fb_if.x_rd) * 1024 + int'(fb_if.y_rd));
         if (done) begin
            lat = i;
            break;
         end
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " hit"}, hit, exp_hit);
      check({name, " hit_x"}, hit_x, exp_hx);
      check({name, " hit_y"}, hit_y, exp_hy);
      check({name, " hit_color"}, hit_color, exp_hc);
      check({name, " read count"}, act_rd.size(), exp_rd.size());
      for (int j = 0; j < exp_rd.size(); j++)
         check($sformatf("%s read[%0d]", name, j), (j < act_rd.size()) ? act_rd[j] : -1, exp_rd[j]);
      check({name, " offscreen reads"}, n_off_reads, 0);
      @(negedge clk);
      check({name, " done pulse width"}, done, 0);
      check({name, " busy after"}, busy, 0);
      check({name, " rd_en after"}, fb_if.rd_en, 0);
      repeat (2) @(negedge clk);
      check({name, " hit held"}, hit, exp_hit);
   endtask

   initial begin
      int x0, y0, n, ndots, done_seen;
      clear_fb();

      // Reset state.
      #12;
      check("reset rd_en", fb_if.rd_en, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset hit", hit, 0);
      check("reset x_rd", fb_if.x_rd, 0);
      check("reset y_rd", fb_if.y_rd, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Directed scenarios.
      run_scan("allbg", 10, 20, 3, 1'b0);
      fb_mem[1*W + 2] = 3'd5;
      run_scan("hit21", 0, 0, 4, 1'b0);
      clear_fb();
      run_scan("corner", 158, 118, 3, 1'b0);
      run_scan("size0", 30, 30, 0, 1'b0);
      run_scan("poke", 10, 20, 3, 1'b1);

      // Hit first, then reset mid-scan must also clear the held hit.
      fb_mem[50*W + 40] = 3'd3;
      run_scan("prehit", 40, 50, 2, 1'b0);
      clear_fb();
      @(negedge clk);
      x_in = 10'd20; y_in = 10'd30; size = 10'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("midreset rd_en", fb_if.rd_en, 0);
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset hit", hit, 0);
      check("midreset x_rd", fb_if.x_rd, 0);
      check("midreset y_rd", fb_if.y_rd, 0);
      check("midreset hit_x", hit_x, 0);
      check("midreset hit_y", hit_y, 0);
      check("midreset hit_color", hit_color, 0);
      @(negedge clk);
      resetn = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("midreset no done", done_seen, 0);
      run_scan("afterreset", 20, 30, 3, 1'b0);

      // Randomized squares, including edge and wrap-around positions.
      for (int r = 0; r < 40; r++) begin
         clear_fb();
         case ($urandom_range(0, 3))
            0:       begin x0 = $urandom_range(150, 165);  y0 = $urandom_range(110, 125); end
            1:       begin x0 = $urandom_range(1018, 1023); y0 = $urandom_range(0, 119);  end
            default: begin x0 = $urandom_range(0, 159);    y0 = $urandom_range(0, 119);  end
         endcase
         n = $urandom_range(0, 7);
         ndots = $urandom_range(0, 3);
         for (int d = 0; d < ndots; d++) begin
            int dx, dy;
            dx = (x0 + $urandom_range(0, 7)) % 1024;
            dy = (y0 + $urandom_range(0, 7)) % 1024;
            if (dx < W && dy < H) fb_mem[dy*W + dx] = 3'($urandom_range(1, 7));
         end
         run_scan($sformatf("rand%0d", r), x0, y0, n, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
